// File: rtl/chk_seq_pkg.sv
// Shared types for the commit sequencer: record kinds, control states and the
// packed record that flows through the ordering FIFO.
package chk_seq_pkg;

    localparam int SEQ_W = 16;

    typedef enum logic [1:0] {
        INST  = 2'd0,
        EVENT = 2'd1
    } chk_kind_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [5:0]  width;
        logic [31:0] data;
    } mem_rec_t;

    typedef struct packed {
        chk_kind_e        kind;
        logic [31:0]      pc;
        logic [31:0]      word;
        logic [31:0]      einst;
        mem_rec_t         rd;
        mem_rec_t         wr;
        logic [SEQ_W-1:0] seq;
    } chk_rec_t;

endpackage

// File: rtl/chk_commit_sequencer_if.sv
// Checker-side record port of the commit sequencer: the sequencer is the
// master, the formal checker wrapper is the slave.
interface chk_commit_sequencer_if;
    import chk_seq_pkg::*;

    // Handshake: a record transfers on every cycle where chk_valid and chk_ready
    // are both high; while chk_valid=1 and chk_ready=0 all head fields hold.
    logic             chk_valid;
    logic             chk_ready;
    chk_kind_e        chk_kind;
    logic [31:0]      chk_pc;
    logic [31:0]      chk_word;
    logic [31:0]      chk_einst;
    logic             chk_rd_valid;
    logic [31:0]      chk_rd_addr;
    logic [5:0]       chk_rd_width;
    logic [31:0]      chk_rd_data;
    logic             chk_wr_valid;
    logic [31:0]      chk_wr_addr;
    logic [5:0]       chk_wr_width;
    logic [31:0]      chk_wr_data;
    logic [SEQ_W-1:0] chk_seq;

    modport master (
        output chk_valid, chk_kind, chk_pc, chk_word, chk_einst,
               chk_rd_valid, chk_rd_addr, chk_rd_width, chk_rd_data,
               chk_wr_valid, chk_wr_addr, chk_wr_width, chk_wr_data, chk_seq,
        input  chk_ready
    );

    modport slave (
        input  chk_valid, chk_kind, chk_pc, chk_word, chk_einst,
               chk_rd_valid, chk_rd_addr, chk_rd_width, chk_rd_data,
               chk_wr_valid, chk_wr_addr, chk_wr_width, chk_wr_data, chk_seq,
        output chk_ready
    );

endinterface

// File: rtl/chk_seq_fifo.sv
// First-word-fall-through record FIFO; the head reads as all-zero when empty so
// the checker never sees stale payload.
module chk_seq_fifo
    import chk_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  chk_rec_t               push_rec,
    input  logic                   pop,
    output chk_rec_t               head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    chk_rec_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_rec;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/chk_commit_sequencer.sv
// Orders commit/trap records from the retire trace for the formal checker.
// Optional watchdog enabled by defining CHK_SEQ_WATCHDOG_EN.
module chk_commit_sequencer
    import chk_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HALT_ON_ERR = 1,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_commit_valid,
    input  logic [31:0] core_commit_inst,
    input  logic [31:0] core_commit_pc,
    input  logic        core_event_valid,
    input  logic [31:0] core_event_cause,
    input  logic [31:0] core_event_pc,
    input  logic [31:0] core_event_inst,
    input  logic        core_rd_valid,
    input  logic [31:0] core_rd_addr,
    input  logic [5:0]  core_rd_width,
    input  logic [31:0] core_rd_data,
    input  logic        core_wr_valid,
    input  logic [31:0] core_wr_addr,
    input  logic [5:0]  core_wr_width,
    input  logic [31:0] core_wr_data,
    output logic        core_stall,
    input  logic        drain_req,
    output logic        drain_done,
    chk_commit_sequencer_if.master chk,
    output logic        err_overflow,
    output logic        err_protocol,
    output logic        wdog_timeout,
    output seq_state_e  dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("chk_commit_sequencer: DEPTH must be a power of 2 >= 2, WDOG_CYCLES >= 1");
    end

    seq_state_e       state;
    chk_rec_t         push_rec;
    chk_rec_t         head;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             full;
    logic             empty;
    logic             push_req;
    logic             push_acc;
    logic             pop;
    logic             proto_hit;
    logic             ovf_hit;
    logic             wdog_hit;
    logic             err_next;
    logic [SEQ_W-1:0] seq_cnt;

    // A halted sequencer ignores the core entirely, including its protocol slips.
    assign push_req  = (state != HALTED) && (core_event_valid || core_commit_valid);
    assign proto_hit = (state != HALTED) &&
                       ((core_event_valid && core_commit_valid) ||
                        ((core_rd_valid || core_wr_valid) && !core_commit_valid));
    assign pop        = !empty && chk.chk_ready;
    assign ovf_hit    = push_req && full && !pop;
    assign push_acc   = push_req && !ovf_hit;
    assign count_next = count + CW'(push_acc) - CW'(pop);
    assign err_next   = err_overflow || ovf_hit || err_protocol || proto_hit ||
                        wdog_timeout || wdog_hit;

    always_comb begin
        push_rec     = '0;
        push_rec.seq = seq_cnt;
        if (core_event_valid) begin
            push_rec.kind  = EVENT;
            push_rec.pc    = core_event_pc;
            push_rec.word  = core_event_cause;
            push_rec.einst = core_event_inst;
        end else begin
            push_rec.kind = INST;
            push_rec.pc   = core_commit_pc;
            push_rec.word = core_commit_inst;
            push_rec.rd   = '{core_rd_valid, core_rd_addr, core_rd_width, core_rd_data};
            push_rec.wr   = '{core_wr_valid, core_wr_addr, core_wr_width, core_wr_data};
        end
    end

    chk_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_acc),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

`ifdef CHK_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_cnt;

    assign wdog_hit = !push_acc && (state == RUN) && !core_stall &&
                      (wdog_cnt == WDW'(WDOG_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b0;
        end else begin
            if (push_acc) begin
                wdog_cnt <= '0;
            end else if (state == RUN && !core_stall && wdog_cnt != WDW'(WDOG_CYCLES)) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_hit) wdog_timeout <= 1'b1;
        end
    end
`else
    assign wdog_hit     = 1'b0;
    assign wdog_timeout = 1'b0;
`endif

    // Stall and drain_done are computed from next-cycle state and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            core_stall   <= 1'b0;
            drain_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
            seq_cnt      <= '0;
        end else begin
            if (push_acc)  seq_cnt      <= seq_cnt + 1'b1;
            if (ovf_hit)   err_overflow <= 1'b1;
            if (proto_hit) err_protocol <= 1'b1;
            case (state)
                RUN: begin
                    if (err_next && HALT_ON_ERR != 0) begin
                        state      <= HALTED;
                        core_stall <= 1'b1;
                        drain_done <= 1'b0;
                    end else if (drain_req) begin
                        state      <= DRAIN;
                        core_stall <= 1'b1;
                        drain_done <= (count_next == '0);
                    end else begin
                        core_stall <= (count_next >= CW'(DEPTH - 1));
                        drain_done <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        core_stall <= (count_next >= CW'(DEPTH - 1));
                        drain_done <= 1'b0;
                    end else begin
                        core_stall <= 1'b1;
                        drain_done <= (count_next == '0);
                    end
                end
                HALTED: begin
                    core_stall <= 1'b1;
                    drain_done <= 1'b0;
                end
                default: begin
                    state      <= HALTED;
                    core_stall <= 1'b1;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state        = state;
    assign chk.chk_valid    = !empty;
    assign chk.chk_kind     = head.kind;
    assign chk.chk_pc       = head.pc;
    assign chk.chk_word     = head.word;
    assign chk.chk_einst    = head.einst;
    assign chk.chk_rd_valid = head.rd.valid;
    assign chk.chk_rd_addr  = head.rd.addr;
    assign chk.chk_rd_width = head.rd.width;
    assign chk.chk_rd_data  = head.rd.data;
    assign chk.chk_wr_valid = head.wr.valid;
    assign chk.chk_wr_addr  = head.wr.addr;
    assign chk.chk_wr_width = head.wr.width;
    assign chk.chk_wr_data  = head.wr.data;
    assign chk.chk_seq      = head.seq;

endmodule

// File: tb/tb_chk_commit_sequencer.sv
// Bench for chk_commit_sequencer: directed scenarios plus randomized traffic
// compared each cycle against a queue-based model of the sequencer rules.
module tb_chk_commit_sequencer;
    import chk_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int HALT  = 1;
    localparam int WDOG  = 8;
    localparam int REC_W = $bits(chk_rec_t);

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        core_commit_valid, core_event_valid;
    logic [31:0] core_commit_inst, core_commit_pc;
    logic [31:0] core_event_cause, core_event_pc, core_event_inst;
    logic        core_rd_valid, core_wr_valid;
    logic [31:0] core_rd_addr, core_rd_data, core_wr_addr, core_wr_data;
    logic [5:0]  core_rd_width, core_wr_width;
    logic        drain_req;
    logic        core_stall, drain_done, err_overflow, err_protocol, wdog_timeout;
    seq_state_e  dbg_state;

    chk_commit_sequencer_if chk_if ();

    chk_commit_sequencer #(.DEPTH(DEPTH), .HALT_ON_ERR(HALT), .WDOG_CYCLES(WDOG)) dut (
        .clock(clock), .reset(reset),
        .core_commit_valid(core_commit_valid), .core_commit_inst(core_commit_inst),
        .core_commit_pc(core_commit_pc), .core_event_valid(core_event_valid),
        .core_event_cause(core_event_cause), .core_event_pc(core_event_pc),
        .core_event_inst(core_event_inst),
        .core_rd_valid(core_rd_valid), .core_rd_addr(core_rd_addr),
        .core_rd_width(core_rd_width), .core_rd_data(core_rd_data),
        .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr),
        .core_wr_width(core_wr_width), .core_wr_data(core_wr_data),
        .core_stall(core_stall), .drain_req(drain_req), .drain_done(drain_done),
        .chk(chk_if), .err_overflow(err_overflow), .err_protocol(err_protocol),
        .wdog_timeout(wdog_timeout), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [REC_W-1:0] exp_q[$];
    seq_state_e m_state;
    bit m_stall, m_done, m_ovf, m_proto, m_wdog;
    int m_seq, m_wcnt;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = RUN;
        {m_stall, m_done, m_ovf, m_proto, m_wdog} = '0;
        m_seq  = 0;
        m_wcnt = 0;
    endtask

    task automatic model_step();
        bit pop, acc, ovf, proto;
        chk_rec_t r;
        pop   = (exp_q.size() > 0) && chk_if.chk_ready;
        acc   = 1'b0;
        ovf   = 1'b0;
        proto = 1'b0;
        if (m_state != HALTED) begin
            proto = (core_event_valid && core_commit_valid) ||
                    ((core_rd_valid || core_wr_valid) && !core_commit_valid);
            if (core_event_valid || core_commit_valid) begin
                if (exp_q.size() == DEPTH && !pop) ovf = 1'b1;
                else acc = 1'b1;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            r = '0;
            if (core_event_valid) begin
                r.kind = EVENT; r.pc = core_event_pc;
                r.word = core_event_cause; r.einst = core_event_inst;
            end else begin
                r.kind = INST; r.pc = core_commit_pc; r.word = core_commit_inst;
                r.rd = '{core_rd_valid, core_rd_addr, core_rd_width, core_rd_data};
                r.wr = '{core_wr_valid, core_wr_addr, core_wr_width, core_wr_data};
            end
            r.seq = 16'(m_seq);
            exp_q.push_back(r);
            m_seq = (m_seq + 1) % 65536;
        end
        m_ovf   = m_ovf | ovf;
        m_proto = m_proto | proto;
`ifdef CHK_SEQ_WATCHDOG_EN
        if (acc) m_wcnt = 0;
        else if (m_state == RUN && !m_stall) begin
            m_wcnt++;
            if (m_wcnt >= WDOG) m_wdog = 1'b1;
        end
`endif
        if (m_state == RUN) begin
            if ((m_ovf || m_proto || m_wdog) && HALT != 0) m_state = HALTED;
            else if (drain_req) m_state = DRAIN;
        end else if (m_state == DRAIN) begin
            if (!drain_req) m_state = RUN;
        end
        m_stall = (m_state != RUN) || (exp_q.size() >= DEPTH - 1);
        m_done  = (m_state == DRAIN) && (exp_q.size() == 0);
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        chk_rec_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q[0];
        check("chk_valid", chk_if.chk_valid, exp_q.size() > 0);
        check("chk_kind", chk_if.chk_kind, e.kind);
        check("chk_pc", chk_if.chk_pc, e.pc);
        check("chk_word", chk_if.chk_word, e.word);
        check("chk_einst", chk_if.chk_einst, e.einst);
        check("chk_rd", {chk_if.chk_rd_valid, chk_if.chk_rd_width, chk_if.chk_rd_addr},
              {e.rd.valid, e.rd.width, e.rd.addr});
        check("chk_rd_data", chk_if.chk_rd_data, e.rd.data);
        check("chk_wr", {chk_if.chk_wr_valid, chk_if.chk_wr_width, chk_if.chk_wr_addr},
              {e.wr.valid, e.wr.width, e.wr.addr});
        check("chk_wr_data", chk_if.chk_wr_data, e.wr.data);
        check("chk_seq", chk_if.chk_seq, e.seq);
        check("core_stall", core_stall, m_stall);
        check("drain_done", drain_done, m_done);
        check("err_overflow", err_overflow, m_ovf);
        check("err_protocol", err_protocol, m_proto);
        check("wdog_timeout", wdog_timeout, m_wdog);
        check("state", dbg_state, m_state);
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        core_commit_valid = 0; core_commit_inst = 0; core_commit_pc = 0;
        core_event_valid = 0; core_event_cause = 0; core_event_pc = 0; core_event_inst = 0;
        core_rd_valid = 0; core_rd_addr = 0; core_rd_width = 0; core_rd_data = 0;
        core_wr_valid = 0; core_wr_addr = 0; core_wr_width = 0; core_wr_data = 0;
        drain_req = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        chk_if.chk_ready = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic drive_commit(logic [31:0] pc, logic [31:0] inst);
        idle_inputs();
        core_commit_valid = 1; core_commit_pc = pc; core_commit_inst = inst;
    endtask

    task automatic rand_cycle(int ready_pct, int err_pct);
        bit misb;
        idle_inputs();
        misb = ($urandom_range(99) < err_pct);
        chk_if.chk_ready = ($urandom_range(99) < ready_pct);
        drain_req = ($urandom_range(99) < 6) ? 1'b1 : (dbg_state == DRAIN && $urandom_range(99) < 80);
        if (!core_stall || misb) begin
            core_event_valid  = ($urandom_range(99) < 4);
            core_commit_valid = ($urandom_range(99) < 65) && (!core_event_valid || misb);
        end
        core_commit_pc = $urandom(); core_commit_inst = $urandom();
        core_event_pc = $urandom(); core_event_cause = $urandom_range(15);
        core_event_inst = $urandom();
        if ((core_commit_valid || misb) && $urandom_range(99) < 30) begin
            core_rd_valid = 1; core_rd_addr = $urandom();
            core_rd_width = 6'($urandom_range(63)); core_rd_data = $urandom();
        end
        if ((core_commit_valid || misb) && $urandom_range(99) < 30) begin
            core_wr_valid = 1; core_wr_addr = $urandom();
            core_wr_width = 6'($urandom_range(63)); core_wr_data = $urandom();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        chk_if.chk_ready = 0;
        reset = 0;
        #3;
        check("rst_valid", chk_if.chk_valid, 0);
        check("rst_stall", core_stall, 0);
        check("rst_seq", chk_if.chk_seq, 0);
        reset_dut();

        // 1: single INST push, immediately accepted
        chk_if.chk_ready = 1;
        drive_commit(32'h8000_0000, 32'h0000_0013);
        step(); idle_inputs();
        check("t1_valid", chk_if.chk_valid, 1);
        check("t1_kind", chk_if.chk_kind, 0);
        check("t1_pc", chk_if.chk_pc, 32'h8000_0000);
        check("t1_word", chk_if.chk_word, 32'h0000_0013);
        check("t1_seq", chk_if.chk_seq, 0);
        step();
        check("t1_popped", chk_if.chk_valid, 0);

        // 2: commit with attached store
        drive_commit(32'h8000_0004, 32'h00a1_2023);
        core_wr_valid = 1; core_wr_addr = 32'h100; core_wr_width = 6'd4;
        core_wr_data = 32'hDEAD_BEEF;
        step(); idle_inputs();
        check("t2_wr_valid", chk_if.chk_wr_valid, 1);
        check("t2_wr_addr", chk_if.chk_wr_addr, 32'h100);
        check("t2_wr_width", chk_if.chk_wr_width, 4);
        check("t2_wr_data", chk_if.chk_wr_data, 32'hDEAD_BEEF);
        check("t2_rd_valid", chk_if.chk_rd_valid, 0);
        check("t2_seq", chk_if.chk_seq, 1);
        step();

        // 3: event and commit collide
        drive_commit(32'h8000_0008, 32'h0000_0073);
        core_event_valid = 1; core_event_cause = 2;
        core_event_pc = 32'h8000_0008; core_event_inst = 32'hFFFF_FFFF;
        step(); idle_inputs();
        check("t3_kind", chk_if.chk_kind, 1);
        check("t3_cause", chk_if.chk_word, 2);
        check("t3_einst", chk_if.chk_einst, 32'hFFFF_FFFF);
        check("t3_proto", err_protocol, 1);
        check("t3_state", dbg_state, 2);
        check("t3_stall", core_stall, 1);
        step();
        check("t3_single", chk_if.chk_valid, 0);

        // 4: fill to overflow, then drain in order
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            drive_commit(32'h1000 + 32'(4 * i), 32'h13);
            step();
            if (i == 1) check("t4_stall_lo", core_stall, 0);
            if (i == 2) check("t4_stall_hi", core_stall, 1);
            if (i == 3) check("t4_ovf_lo", err_overflow, 0);
        end
        idle_inputs();
        check("t4_ovf", err_overflow, 1);
        check("t4_model_depth", exp_q.size(), 4);
        chk_if.chk_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("t4_seq", chk_if.chk_seq, i);
            check("t4_pc", chk_if.chk_pc, 32'h1000 + 32'(4 * i));
            step();
        end
        check("t4_empty", chk_if.chk_valid, 0);

        // 5: drain with two records queued
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            drive_commit(32'h2000 + 32'(4 * i), 32'h13);
            step();
        end
        idle_inputs();
        drain_req = 1; chk_if.chk_ready = 1;
        step();
        check("t5_stall", core_stall, 1);
        check("t5_done_lo", drain_done, 0);
        step();
        check("t5_done", drain_done, 1);
        drain_req = 0;
        step();
        check("t5_run", dbg_state, 0);
        check("t5_stall_lo", core_stall, 0);

        // 6: watchdog on an idle core
        reset_dut();
        repeat (WDOG - 1) step();
        check("t6_wdog_pre", wdog_timeout, 0);
        step();
`ifdef CHK_SEQ_WATCHDOG_EN
        check("t6_wdog", wdog_timeout, 1);
`else
        repeat (20) step();
        check("t6_wdog_off", wdog_timeout, 0);
`endif

        // Randomized traffic, several reset-separated runs
        for (int p = 0; p < 6; p++) begin
            reset_dut();
            for (int c = 0; c < 600; c++) begin
                rand_cycle(20 + 15 * p, (p == 0) ? 0 : 1);
                step();
            end
        end

        idle_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
